// File: rtl/nn_accel_pkg.sv
// Shared types and defaults for the accelerator's buffer/stream blocks.
package nn_accel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } rd_state_t;

    localparam int DATA_WIDTH = 32;
    localparam int MAX_LEN    = 1024;

endpackage

// File: rtl/buffer_stream_reader.sv
// Read-side master for the data FIFO: pops len words from the FIFO head and
// streams them out on a valid/ready interface through a 1-entry output
// register, tagging the final word with out_last and pulsing done afterwards.
module buffer_stream_reader #(
    parameter int DATA_WIDTH = nn_accel_pkg::DATA_WIDTH,
    parameter int MAX_LEN    = nn_accel_pkg::MAX_LEN,
    parameter int LEN_W      = $clog2(MAX_LEN) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    output logic                  done,
    output logic                  buf_read_enable,
    input  logic [DATA_WIDTH-1:0] buf_read_data,
    input  logic                  buf_empty,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    import nn_accel_pkg::*;

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

    rd_state_t             state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      pop_cnt_q, pop_cnt_d;
    logic [LEN_W-1:0]      sent_cnt_q, sent_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  pop;
    logic                  hs;

    // Next-state, pop strobe and output-register update.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pop_cnt_d   = pop_cnt_q;
        sent_cnt_d  = sent_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        pop         = 1'b0;
        hs          = out_valid_q & out_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d    = STREAM;
                        // Oversized requests are clamped to the largest legal transfer.
                        len_d      = (len > MAX_LEN_W) ? MAX_LEN_W : len;
                        pop_cnt_d  = '0;
                        sent_cnt_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            STREAM: begin
                // Pop only when there is room: register empty or draining this cycle.
                pop = (pop_cnt_q < len_q) & ~buf_empty & (~out_valid_q | out_ready);
                if (pop) begin
                    out_data_d  = buf_read_data;
                    out_valid_d = 1'b1;
                    out_last_d  = (pop_cnt_q == len_q - LEN_W'(1));
                    pop_cnt_d   = pop_cnt_q + LEN_W'(1);
                end else if (hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if (hs) begin
                    sent_cnt_d = sent_cnt_q + LEN_W'(1);
                    if (out_last_q) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any word held in the output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            pop_cnt_q   <= '0;
            sent_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pop_cnt_q   <= pop_cnt_d;
            sent_cnt_q  <= sent_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign buf_read_enable = pop;
    assign busy            = (state_q == STREAM) || (state_q == DONE);
    assign done            = (state_q == DONE);
    assign out_valid       = out_valid_q;
    assign out_last        = out_last_q;
    assign out_data        = out_data_q;

endmodule

// File: tb/tb_buffer_stream_reader.sv
// Directed bench for buffer_stream_reader with a small FIFO model and a
// negedge monitor logging pops, handshakes and done pulses.
module tb_buffer_stream_reader;

    localparam int DW    = 32;
    localparam int LEN_W = 11;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy, done, buf_read_enable, buf_empty;
    logic [DW-1:0]    buf_read_data;
    logic             out_valid, out_last, out_ready;
    logic [DW-1:0]    out_data;

    always #5 clk = ~clk;

    buffer_stream_reader dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .len             (len),
        .busy            (busy),
        .done            (done),
        .buf_read_enable (buf_read_enable),
        .buf_read_data   (buf_read_data),
        .buf_empty       (buf_empty),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_last        (out_last),
        .out_ready       (out_ready)
    );

    // FIFO model: mem/wr_ptr owned by the stimulus, rd_ptr by the pop process.
    logic [DW-1:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign buf_empty     = (rd_ptr == wr_ptr);
    assign buf_read_data = mem[rd_ptr];

    // FIFO pop on read_enable.
    always @(posedge clk) if (buf_read_enable) rd_ptr <= rd_ptr + 1;

    // Monitor state.
    int          pops = 0, hs_cnt = 0, done_cnt = 0, rx_n = 0, ncyc = 0;
    int          empty_pop_err = 0, stab_err = 0;
    int          last_pop_neg = 0, done_neg = 0;
    logic [DW-1:0] rx_data [0:63];
    logic        rx_last [0:63];
    int          rx_neg  [0:63];
    logic        prev_stall = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;

    // Sample everything mid-cycle: a pop/handshake seen here happens at the next posedge.
    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (buf_read_enable) begin
            pops         <= pops + 1;
            last_pop_neg <= ncyc;
            if (buf_empty) empty_pop_err <= empty_pop_err + 1;
        end
        if (out_valid && out_ready) begin
            rx_data[rx_n] <= out_data;
            rx_last[rx_n] <= out_last;
            rx_neg[rx_n]  <= ncyc;
            rx_n          <= rx_n + 1;
            hs_cnt        <= hs_cnt + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_neg <= ncyc;
        end
        if (prev_stall && reset_n &&
            (!out_valid || out_data != prev_data || out_last != prev_last))
            stab_err <= stab_err + 1;
        prev_stall <= out_valid & ~out_ready;
        prev_data  <= out_data;
        prev_last  <= out_last;
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wr_ptr] = d;
        wr_ptr++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = '0;
    endtask

    task automatic wait_done(input int max, input string tag);
        int base = done_cnt;
        for (int i = 0; i < max; i++) begin
            if (done_cnt != base) break;
            tick();
        end
        chk(tag, 64'(done_cnt != base), 64'd1);
        tick();
    endtask

    function automatic logic [63:0] outs();
        return {busy, done, buf_read_enable, out_valid, out_last, out_data};
    endfunction

    initial begin
        int p0, r0, pd, h0;
        logic [DW-1:0] seq6 [0:8];
        reset_n   = 1'b0;
        start     = 1'b0;
        len       = '0;
        out_ready = 1'b1;

        // 1: reset with FIFO preloaded
        for (int i = 0; i < 4; i++) push(DW'(32'hA0 + i));
        tick(); tick();
        chk("reset_outs", outs(), 64'd0);
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("idle_no_pop_en", 64'(buf_read_enable), 64'd0);
        chk("idle_no_pops", 64'(pops), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        // 2: basic full-throughput transfer of 4
        p0 = pops; r0 = rx_n;
        pulse_start(11'd4);
        chk("basic_busy", 64'(busy), 64'd1);
        wait_done(20, "basic_done_timeout");
        chk("basic_pops", 64'(pops - p0), 64'd4);
        chk("basic_cnt", 64'(rx_n - r0), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("basic_data%0d", i), 64'(rx_data[r0+i]), 64'(32'hA0 + i));
            chk($sformatf("basic_last%0d", i), 64'(rx_last[r0+i]), (i == 3) ? 64'd1 : 64'd0);
        end
        for (int i = 1; i < 4; i++)
            chk($sformatf("basic_b2b%0d", i), 64'(rx_neg[r0+i] - rx_neg[r0+i-1]), 64'd1);
        chk("basic_latency", 64'(rx_neg[r0+3] - last_pop_neg), 64'd1);
        chk("basic_done_lat", 64'(done_neg - rx_neg[r0+3]), 64'd1);
        chk("basic_fifo_empty", 64'(buf_empty), 64'd1);

        // 3: backpressure on first word
        for (int i = 0; i < 3; i++) push(DW'(32'hB0 + i));
        p0 = pops; r0 = rx_n;
        out_ready = 1'b0;
        pulse_start(11'd3);
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold%0d", i), 64'(out_data), 64'hB0);
            chk($sformatf("bp_pops%0d", i), 64'(pops - p0), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        wait_done(20, "bp_done_timeout");
        chk("bp_pops", 64'(pops - p0), 64'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("bp_data%0d", i), 64'(rx_data[r0+i]), 64'(32'hB0 + i));
        chk("bp_stable", 64'(stab_err), 64'd0);

        // 4: starved FIFO, 2 words now, 3 more later
        push(32'hC0); push(32'hC1);
        p0 = pops; r0 = rx_n;
        pulse_start(11'd5);
        repeat (6) tick();
        chk("starve_valid_gap", 64'(out_valid), 64'd0);
        chk("starve_busy", 64'(busy), 64'd1);
        chk("starve_pops", 64'(pops - p0), 64'd2);
        for (int i = 2; i < 5; i++) push(DW'(32'hC0 + i));
        wait_done(20, "starve_done_timeout");
        chk("starve_total_pops", 64'(pops - p0), 64'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("starve_data%0d", i), 64'(rx_data[r0+i]), 64'(32'hC0 + i));
            chk($sformatf("starve_last%0d", i), 64'(rx_last[r0+i]), (i == 4) ? 64'd1 : 64'd0);
        end
        chk("starve_no_empty_pop", 64'(empty_pop_err), 64'd0);

        // 5: zero-length start, then start ignored while busy
        p0 = pops;
        pulse_start(11'd0);
        chk("zero_done", 64'(done), 64'd1);
        tick();
        chk("zero_done_clear", 64'(done), 64'd0);
        chk("zero_busy_clear", 64'(busy), 64'd0);
        chk("zero_no_pops", 64'(pops - p0), 64'd0);
        push(32'hD0); push(32'hD1); push(32'hD2);
        p0 = pops; r0 = rx_n;
        pulse_start(11'd2);
        pulse_start(11'd5);
        wait_done(20, "ign_done_timeout");
        repeat (3) tick();
        chk("ign_pops", 64'(pops - p0), 64'd2);
        chk("ign_data0", 64'(rx_data[r0]), 64'hD0);
        chk("ign_data1", 64'(rx_data[r0+1]), 64'hD1);
        chk("ign_fifo_left", 64'(wr_ptr - rd_ptr), 64'd1);

        // 6: reset after 2 of 8 words sent, then a len=1 transfer
        seq6[0] = 32'hD2;
        for (int i = 0; i < 8; i++) begin
            push(DW'(32'hE0 + i));
            seq6[i+1] = DW'(32'hE0 + i);
        end
        p0 = pops; r0 = rx_n; h0 = hs_cnt;
        pulse_start(11'd8);
        for (int i = 0; i < 20 && (hs_cnt - h0) < 2; i++) tick();
        chk("mid_two_sent", 64'(hs_cnt - h0), 64'd2);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_outs", outs(), 64'd0);
        pd = pops - p0;
        chk("mid_sent0", 64'(rx_data[r0]), 64'(seq6[0]));
        chk("mid_sent1", 64'(rx_data[r0+1]), 64'(seq6[1]));
        chk("mid_pops_range", 64'(pd >= 2 && pd <= 3), 64'd1);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("mid_idle", 64'(busy), 64'd0);
        chk("mid_no_pops_after", 64'(pops - p0), 64'(pd));
        r0 = rx_n;
        pulse_start(11'd1);
        wait_done(20, "post_done_timeout");
        chk("post_pops", 64'(pops - p0), 64'(pd + 1));
        chk("post_data", 64'(rx_data[r0]), 64'(seq6[pd]));
        chk("post_last", 64'(rx_last[r0]), 64'd1);
        chk("final_stable", 64'(stab_err), 64'd0);
        chk("final_no_empty_pop", 64'(empty_pop_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
